// File: rtl/pc_next_unit_if.sv
// Fetch-side bundle for pc_next_unit: redirect sources and controls in,
// registered fetch address and status pulses out.
interface pc_next_unit_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 8,
  parameter int SEL_W   = 3
);
  logic [NUM_SRC*WIDTH-1:0] src_bus;
  logic [SEL_W-1:0]         sel;
  logic                     sel_valid;
  logic                     stall;
  logic [WIDTH-1:0]         pc;
  logic                     redirect_pending;
  logic                     redirect_taken;
  logic                     misaligned;
  logic                     sel_err;

  modport master (
    output src_bus, sel, sel_valid, stall,
    input  pc, redirect_pending, redirect_taken, misaligned, sel_err
  );

  modport slave (
    input  src_bus, sel, sel_valid, stall,
    output pc, redirect_pending, redirect_taken, misaligned, sel_err
  );
endinterface

// File: rtl/pc_next_unit.sv
// Registered next-PC generator: picks a redirect source, holds during stalls and
// latches the latest stalled redirect so it is applied once the stall releases.
module pc_next_unit #(
  parameter int               WIDTH        = 32,
  parameter int               NUM_SRC      = 8,
  parameter int               SEL_W        = 3,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int               INC          = 4,
  parameter int               ALIGN_BITS   = 2
) (
  input  logic          clk,
  input  logic          rst,
  pc_next_unit_if.slave bus
);

  localparam logic [SEL_W:0]   NUM_SRC_L = (SEL_W+1)'(NUM_SRC);
  localparam logic [WIDTH-1:0] INC_L     = WIDTH'(INC);

  function automatic logic [WIDTH-1:0] align_mask();
    logic [WIDTH-1:0] m;
    m = '1;
    m = m << ALIGN_BITS;
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] align_target(input logic [WIDTH-1:0] t);
    return t & align_mask();
  endfunction

  function automatic logic is_misaligned(input logic [WIDTH-1:0] t);
    return |(t & ~align_mask());
  endfunction

  logic [WIDTH-1:0] pc_p0;
  logic [WIDTH-1:0] pend_tgt_p0;
  logic             pend_vld_p0;
  logic             taken_p0;
  logic             mis_p0;
  logic             sel_err_p0;

  logic             in_range;
  logic             req_vld;
  logic [WIDTH-1:0] req_tgt;
  logic             use_redir;
  logic [WIDTH-1:0] redir_tgt;
  logic [WIDTH-1:0] next_pc;

  always_comb begin
    in_range  = ({1'b0, bus.sel} < NUM_SRC_L);
    req_vld   = bus.sel_valid & in_range;
    req_tgt   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.sel == SEL_W'(k)) req_tgt = bus.src_bus[k*WIDTH +: WIDTH];
    end
    // A fresh request outranks a latched one; the latched target is dropped.
    use_redir = req_vld | pend_vld_p0;
    redir_tgt = req_vld ? req_tgt : pend_tgt_p0;
    next_pc   = use_redir ? align_target(redir_tgt) : pc_p0 + INC_L;
  end

  // ---- stage p0: registered pc, pending flag and event pulses ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0       <= RESET_VECTOR;
      pend_vld_p0 <= 1'b0;
      taken_p0    <= 1'b0;
      mis_p0      <= 1'b0;
      sel_err_p0  <= 1'b0;
    end else begin
      sel_err_p0 <= bus.sel_valid & ~in_range;
      if (!bus.stall) begin
        pc_p0       <= next_pc;
        pend_vld_p0 <= 1'b0;
        taken_p0    <= use_redir;
        mis_p0      <= use_redir & is_misaligned(redir_tgt);
      end else begin
        taken_p0 <= 1'b0;
        mis_p0   <= 1'b0;
        if (req_vld) pend_vld_p0 <= 1'b1;
      end
    end
  end

  // Target payload only matters while pend_vld_p0 is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (bus.stall && req_vld) pend_tgt_p0 <= req_tgt;
  end

  assign bus.pc               = pc_p0;
  assign bus.redirect_pending = pend_vld_p0;
  assign bus.redirect_taken   = taken_p0;
  assign bus.misaligned       = mis_p0;
  assign bus.sel_err          = sel_err_p0;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit with five redirect sources.
module tb_pc_next_unit;

  localparam int NSRC = 5;

  logic clk;
  logic rst;

  pc_next_unit_if #(.WIDTH(32), .NUM_SRC(NSRC), .SEL_W(3)) bus ();

  pc_next_unit #(
    .WIDTH(32), .NUM_SRC(NSRC), .SEL_W(3),
    .RESET_VECTOR(32'h0000_0000), .INC(4), .ALIGN_BITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic        taken;
    logic        mis;
    logic        serr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] srcs [0:7];
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_pend_tgt;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic load_src();
    for (int k = 0; k < NSRC; k++) bus.src_bus[k*32 +: 32] = srcs[k];
  endtask

  task automatic step(input logic st, input logic sv, input logic [2:0] s);
    exp_t        e;
    logic        vreq;
    logic [31:0] t;
    bus.stall     = st;
    bus.sel_valid = sv;
    bus.sel       = s;
    vreq   = sv && (s < 3'(NSRC));
    t      = srcs[s];
    e.serr = sv && !(s < 3'(NSRC));
    e.taken = 1'b0;
    e.mis   = 1'b0;
    if (!st) begin
      if (vreq || m_pend) begin
        if (!vreq) t = m_pend_tgt;
        e.taken = 1'b1;
        e.mis   = (t[1:0] != 2'b00);
        m_pc    = {t[31:2], 2'b00};
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_pend = 1'b0;
    end else if (vreq) begin
      m_pend     = 1'b1;
      m_pend_tgt = t;
    end
    e.pc   = m_pc;
    e.pend = m_pend;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("pc",      bus.pc,                    e.pc);
      chk("pending", 32'(bus.redirect_pending), 32'(e.pend));
      chk("taken",   32'(bus.redirect_taken),   32'(e.taken));
      chk("misalgn", 32'(bus.misaligned),       32'(e.mis));
      chk("sel_err", 32'(bus.sel_err),          32'(e.serr));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < 8; k++) srcs[k] = 32'h0;
    bus.src_bus   = '0;
    bus.sel       = '0;
    bus.sel_valid = 1'b0;
    bus.stall     = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",      bus.pc,                    32'h0);
    chk("rst_pending", 32'(bus.redirect_pending), 32'h0);
    chk("rst_taken",   32'(bus.redirect_taken),   32'h0);
    chk("rst_misalgn", 32'(bus.misaligned),       32'h0);
    chk("rst_sel_err", 32'(bus.sel_err),          32'h0);
    rst    = 1'b0;
    m_pc   = 32'h0;
    m_pend = 1'b0;
    m_pend_tgt = 32'h0;

    // sequential fetch
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    chk("seq_pc12", bus.pc, 32'h0000_000C);

    // direct redirect
    srcs[1] = 32'h200; srcs[2] = 32'h300; srcs[3] = 32'h100; srcs[4] = 32'h202;
    load_src();
    step(0, 1, 3);
    chk("direct_pc", bus.pc, 32'h100);
    step(0, 0, 0);
    chk("direct_next", bus.pc, 32'h104);

    // stalled redirect, latest wins
    step(1, 1, 1); step(1, 1, 2); step(1, 0, 0);
    chk("stall_hold", bus.pc, 32'h104);
    step(0, 0, 0);
    chk("stall_apply", bus.pc, 32'h300);
    step(0, 0, 0);

    // invalid select, free-running and stalled
    step(0, 1, 6); step(0, 0, 0);
    step(1, 1, 6); step(0, 0, 0);

    // misaligned target, direct and via pending latch
    step(0, 1, 4);
    chk("mis_pc", bus.pc, 32'h200);
    step(0, 0, 0);
    step(1, 1, 4); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);

    // new request beats pending target
    step(1, 1, 1); step(0, 1, 3);
    chk("prio_pc", bus.pc, 32'h100);
    step(0, 0, 0);

    // async reset while a redirect is pending
    step(1, 1, 2);
    #2;
    bus.stall = 1'b0; bus.sel_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_pc",      bus.pc,                    32'h0);
    chk("arst_pending", 32'(bus.redirect_pending), 32'h0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_pc   = 32'h0;
    m_pend = 1'b0;
    step(0, 0, 0);
    chk("post_rst_pc", bus.pc, 32'h4);

    // wrap at top of address space
    srcs[0] = 32'hFFFF_FFFC;
    load_src();
    step(0, 1, 0); step(0, 0, 0);
    chk("wrap_pc", bus.pc, 32'h0);

    // mixed random traffic
    for (int i = 0; i < 60; i++) begin
      if ((i % 8) == 0) begin
        for (int k = 0; k < NSRC; k++) srcs[k] = $urandom & 32'h000F_FFFF;
        load_src();
      end
      step(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Registered program-counter generator for the pipelined RISC-V core's fetch stage. It replaces a purely combinational next-PC source mux with a parametrised unit that provides:
- a configurable number of redirect sources;
- a held PC during stalls;
- a pending-redirect latch, so redirects raised during a stall are never lost;
- alignment checking on applied targets.

The unit drives the instruction-memory address each cycle.

## Interface
Parameters:
- WIDTH, 32, PC and target width in bits.
- NUM_SRC, 8, number of redirect target sources (2..16).
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_SRC.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INC, 4, sequential increment added to pc.
- ALIGN_BITS, 2, number of low target bits that must be zero.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- src_bus  input  NUM_SRC*WIDTH  flattened targets; source k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  index of the redirect source.
- sel_valid  input  1  redirect request this cycle.
- stall  input  1  hold pc; do not advance.
- pc  output  WIDTH  current fetch address (registered).
- redirect_pending  output  1  a redirect is latched, waiting for stall release (registered).
- redirect_taken  output  1  one-cycle pulse: pc was loaded from a redirect on the last edge.
- misaligned  output  1  one-cycle pulse: the applied target had nonzero low ALIGN_BITS.
- sel_err  output  1  one-cycle pulse: sel_valid was raised with sel >= NUM_SRC.

## Operation
**Reset.** While rst is high, the outputs take these values:
- pc = RESET_VECTOR.
- pending register cleared; redirect_pending = 0.
- redirect_taken, misaligned and sel_err = 0.

**Request validity.** A request is valid when sel_valid = 1 and sel < NUM_SRC.
- The target is src_bus slice sel.
- If sel_valid = 1 and sel >= NUM_SRC, the request is discarded: sel_err pulses, and pc and the pending register are unaffected.

**next_pc priority** (computed each cycle):
1. Valid request: its target.
2. Otherwise, if redirect_pending: the pending target.
3. Otherwise: pc + INC, with modulo 2**WIDTH wrap.

**Stall = 0.**
- pc <= next_pc.
- redirect_pending <= 0.
- redirect_taken pulses if source 1 or 2 of the priority list was used.

**Stall = 1.**
- pc holds.
- A valid request overwrites the pending register (latest request wins) and sets redirect_pending.
- With no request, the pending state holds.

**Alignment.**
- When a redirect target is loaded into pc, its low ALIGN_BITS are forced to zero.
- misaligned pulses if any of those bits were 1.
- The check is made when the target is applied, not when it is latched.
- Sequential increments are never checked.

**Pulse outputs.** redirect_taken, misaligned and sel_err are registered and high for exactly one cycle per event.

## Timing
- **Latency.** One cycle from request to pc update: a request sampled at edge N appears on pc after edge N (visible during cycle N+1).
- **Stalled redirect.** A redirect raised during a stall reaches pc on the first edge at which stall = 0. redirect_pending is high from the edge after capture until that edge.
- **Simultaneous valid request and pending redirect with stall = 0.** The new request wins; the pending target is dropped.
- **Reset mid-stall with pending redirect.** The pending redirect is lost. pc = RESET_VECTOR immediately, asynchronously.
- **First edge after rst deasserts with stall = 0.** pc becomes RESET_VECTOR + INC unless a request is present.
- **Wrap.** pc = 2**WIDTH - INC with no redirect gives pc = 0 next cycle; no flag is raised.
- **Output timing.** All outputs change only on clk or rst; none is combinational from the inputs.

## Test plan
- **Sequential fetch.** Reset, then deassert with stall = 0 and no requests → pc = 0, 4, 8, 12 on successive cycles; redirect_taken = 0.
- **Direct redirect.** sel_valid = 1, sel = 3, slice 3 = 0x100, stall = 0 → next cycle pc = 0x100 and redirect_taken = 1; the following cycle pc = 0x104 and redirect_taken = 0.
- **Stalled redirect.** stall = 1 for 3 cycles. Redirect sel = 1 (0x200) arrives in stall cycle 1, then sel = 2 (0x300) in stall cycle 2 → pc holds throughout and redirect_pending = 1. After stall drops, pc = 0x300, redirect_pending = 0, then pc = 0x304.
- **Invalid select.** NUM_SRC = 5, sel_valid = 1, sel = 6 → sel_err pulses once and pc continues +4. The same with stall = 1 leaves redirect_pending = 0.
- **Misaligned target.** Target 0x202 applied → pc = 0x200 and misaligned pulses once. With target 0x202 latched during a stall, misaligned pulses only on the apply cycle.
- **Async reset and wrap.** Assert rst mid-cycle with redirect_pending = 1 → pc = RESET_VECTOR before the next edge and redirect_pending = 0. Then set pc = 0xFFFF_FFFC with no redirect → pc = 0 next cycle.
